// File: rtl/hsid_mse_lanes_if.sv
// Band-pack input and mean-result output handshakes of the mean-error engine.
interface hsid_mse_lanes_if #(
    parameter int WORD_WIDTH        = 32,
    parameter int HSP_BANDS_WIDTH   = 9,
    parameter int HSP_LIBRARY_WIDTH = 8
);
    logic                         mode;
    logic                         band_pack_valid;
    logic                         band_pack_ready;
    logic                         band_pack_start;
    logic                         band_pack_last;
    logic [WORD_WIDTH-1:0]        band_pack_a;
    logic [WORD_WIDTH-1:0]        band_pack_b;
    logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref;
    logic [HSP_BANDS_WIDTH-1:0]   hsp_bands;
    logic [WORD_WIDTH-1:0]        mse_value;
    logic [HSP_LIBRARY_WIDTH-1:0] mse_ref;
    logic                         mse_valid;
    logic                         mse_ready;
    logic                         acc_of;
    logic                         div_zero;

    modport master (
        output mode, band_pack_valid, band_pack_start, band_pack_last,
               band_pack_a, band_pack_b, hsp_ref, hsp_bands, mse_ready,
        input  band_pack_ready, mse_value, mse_ref, mse_valid, acc_of, div_zero
    );

    modport slave (
        input  mode, band_pack_valid, band_pack_start, band_pack_last,
               band_pack_a, band_pack_b, hsp_ref, hsp_bands, mse_ready,
        output band_pack_ready, mse_value, mse_ref, mse_valid, acc_of, div_zero
    );
endinterface

// File: rtl/hsid_mse_lanes.sv
// Mean squared/absolute error engine: per-lane difference terms, vector
// accumulation, lane sum, then a bit-serial restoring divide by the band count.
module hsid_mse_lane #(
    parameter int DW    = 16,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             flush,
    input  logic             fire,
    input  logic             mode,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic             e1_vld,
    input  logic             e1_start,
    input  logic             drain,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);
    logic [DW-1:0]   d;
    logic [2*DW-1:0] term, term_nx;
    logic [ACC_W:0]  sum;

    assign d       = (a >= b) ? a - b : b - a;
    assign term_nx = mode ? (2*DW)'(d) : (2*DW)'(d) * (2*DW)'(d);
    assign sum     = {1'b0, acc} + {1'b0, ACC_W'(term)};

    always_ff @(posedge clk) begin
        if (flush) begin
            term <= '0;
            acc  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (fire) term <= term_nx;
            if (e1_vld) begin
                if (e1_start) begin
                    acc <= ACC_W'(term);
                    ovf <= 1'b0;
                end else begin
                    acc <= sum[ACC_W-1:0];
                    ovf <= ovf | sum[ACC_W];
                end
            end else if (drain) begin
                acc <= '0;
                ovf <= 1'b0;
            end
        end
    end
endmodule

module hsid_mse_lanes #(
    parameter int WORD_WIDTH        = 32,
    parameter int CHANNELS          = 2,
    parameter int DATA_WIDTH_ACC    = 40,
    parameter int HSP_BANDS_WIDTH   = 9,
    parameter int HSP_LIBRARY_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    hsid_mse_lanes_if.slave  bus,
    output logic             busy
);
    localparam int DATA_WIDTH = WORD_WIDTH / CHANNELS;
    localparam int SUM_W      = DATA_WIDTH_ACC + $clog2(CHANNELS);
    localparam int BW         = HSP_BANDS_WIDTH;
    localparam int CW         = $clog2(SUM_W);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    logic flush, fire, load, pending, mode_q, mode_eff;
    logic e1_vld, e1_start, e1_last, e2_open, e2_done, e3_full, e3_ovf, ovf_q;
    logic [HSP_LIBRARY_WIDTH-1:0] e1_ref, e2_ref, e3_ref;
    logic [BW-1:0]                e1_bands, e2_bands, e3_bands;
    logic [CHANNELS-1:0][DATA_WIDTH_ACC-1:0] lane_acc;
    logic [CHANNELS-1:0]          lane_ovf;
    logic [SUM_W-1:0]             lane_sum, e3_sum, dvd, quo_nx;
    logic [BW-1:0]                dvs, rem, rem_nx;
    logic [BW:0]                  shifted, diff;
    logic                         ge, sat;
    logic [SUM_W+WORD_WIDTH-1:0]  qx;
    logic [CW-1:0]                cnt;
    state_t                       state;

    assign flush               = rst | clear;
    assign bus.band_pack_ready = ~pending & ~flush;
    assign fire                = bus.band_pack_valid & bus.band_pack_ready;
    assign mode_eff            = bus.band_pack_start ? bus.mode : mode_q;
    assign load                = e3_full & ((state == IDLE) | ((state == HOLD) & bus.mse_ready));
    assign busy                = e1_vld | e2_open | e2_done | e3_full | (state != IDLE);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        hsid_mse_lane #(.DW(DATA_WIDTH), .ACC_W(DATA_WIDTH_ACC)) u_lane (
            .clk      (clk),
            .flush    (flush),
            .fire     (fire),
            .mode     (mode_eff),
            .a        (bus.band_pack_a[i*DATA_WIDTH +: DATA_WIDTH]),
            .b        (bus.band_pack_b[i*DATA_WIDTH +: DATA_WIDTH]),
            .e1_vld   (e1_vld),
            .e1_start (e1_start),
            .drain    (e2_done),
            .acc      (lane_acc[i]),
            .ovf      (lane_ovf[i])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < CHANNELS; i++) lane_sum = lane_sum + SUM_W'(lane_acc[i]);
    end

    // One restoring step: dividend bits leave the top of dvd, quotient bits enter the bottom.
    assign shifted = {rem, dvd[SUM_W-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign ge      = shifted >= {1'b0, dvs};
    assign rem_nx  = ge ? diff[BW-1:0] : shifted[BW-1:0];
    assign quo_nx  = {dvd[SUM_W-2:0], ge};
    assign qx      = {{WORD_WIDTH{1'b0}}, quo_nx};
    assign sat     = |qx[SUM_W+WORD_WIDTH-1:WORD_WIDTH];

    always_ff @(posedge clk) begin
        if (flush) begin
            pending <= 1'b0; mode_q <= 1'b0;
            e1_vld <= 1'b0; e1_start <= 1'b0; e1_last <= 1'b0; e1_ref <= '0; e1_bands <= '0;
            e2_open <= 1'b0; e2_done <= 1'b0; e2_ref <= '0; e2_bands <= '0;
            e3_full <= 1'b0; e3_ovf <= 1'b0; e3_sum <= '0; e3_ref <= '0; e3_bands <= '0;
            dvd <= '0; dvs <= '0; rem <= '0; cnt <= '0; ovf_q <= 1'b0;
            state <= IDLE;
            bus.mse_value <= '0; bus.mse_ref <= '0; bus.mse_valid <= 1'b0;
            bus.acc_of <= 1'b0; bus.div_zero <= 1'b0;
        end else begin
            e1_vld <= fire;
            if (fire) begin
                mode_q   <= mode_eff;
                e1_start <= bus.band_pack_start;
                e1_last  <= bus.band_pack_last;
                e1_ref   <= bus.hsp_ref;
                e1_bands <= bus.hsp_bands;
            end
            if (fire && bus.band_pack_last) pending <= 1'b1;
            else if (load)                  pending <= 1'b0;

            e2_done <= e1_vld & e1_last;
            if (e1_vld) begin
                e2_open <= ~e1_last;
                if (e1_last) begin
                    e2_ref   <= e1_ref;
                    e2_bands <= e1_bands;
                end
            end

            if (e2_done) begin
                e3_full  <= 1'b1;
                e3_sum   <= lane_sum;
                e3_ovf   <= |lane_ovf;
                e3_ref   <= e2_ref;
                e3_bands <= e2_bands;
            end else if (load) begin
                e3_full <= 1'b0;
            end

            case (state)
                RUN: begin
                    dvd <= quo_nx;
                    rem <= rem_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(SUM_W-1)) begin
                        state          <= HOLD;
                        bus.mse_valid  <= 1'b1;
                        bus.mse_value  <= sat ? '1 : qx[WORD_WIDTH-1:0];
                        bus.acc_of     <= sat | ovf_q;
                        bus.div_zero   <= 1'b0;
                    end
                end
                HOLD: if (bus.mse_ready) begin
                    state         <= IDLE;
                    bus.mse_valid <= 1'b0;
                end
                default: ;
            endcase

            if (load) begin
                dvd         <= e3_sum;
                dvs         <= e3_bands;
                rem         <= '0;
                cnt         <= '0;
                ovf_q       <= e3_ovf;
                bus.mse_ref <= e3_ref;
                if (e3_bands == '0) begin
                    state         <= HOLD;
                    bus.mse_valid <= 1'b1;
                    bus.mse_value <= '1;
                    bus.div_zero  <= 1'b1;
                    bus.acc_of    <= e3_ovf;
                end else begin
                    state         <= RUN;
                    bus.mse_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_hsid_mse_lanes.sv
// Randomized and directed checks of hsid_mse_lanes against an arithmetic model.
module tb_hsid_mse_lanes;
    localparam int WW = 32, CH = 2, DW = 16, ACC = 40, BW = 9, LW = 8;

    logic clk = 1'b0, rst = 1'b1, clear = 1'b0, busy;
    always #5 clk = ~clk;

    hsid_mse_lanes_if #(.WORD_WIDTH(WW), .HSP_BANDS_WIDTH(BW), .HSP_LIBRARY_WIDTH(LW)) bif ();

    hsid_mse_lanes #(.WORD_WIDTH(WW), .CHANNELS(CH), .DATA_WIDTH_ACC(ACC),
                     .HSP_BANDS_WIDTH(BW), .HSP_LIBRARY_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .bus(bif), .busy(busy));

    typedef struct {
        longint unsigned val;
        int ref_id;
        bit of, dz, chk_of;
        int lat, t;
    } exp_t;

    exp_t q[$];
    logic [31:0] va[$], vb[$];
    int cyc = 0, checks = 0, errors = 0, accepted = 0, results = 0, vcyc = 0;
    bit seen = 0, rnd_on = 0;
    longint unsigned last_val;
    int last_ref;
    bit last_of, last_dz;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain per-lane arithmetic over the whole vector, then integer divide.
    function automatic exp_t model(input bit m, input int r, input int bands);
        exp_t e;
        longint unsigned lacc[CH], sum, qt, x, y, d;
        bit ovf = 0;
        for (int i = 0; i < CH; i++) lacc[i] = 0;
        for (int j = 0; j < va.size(); j++)
            for (int i = 0; i < CH; i++) begin
                x = (va[j] >> (i*DW)) & 64'hFFFF;
                y = (vb[j] >> (i*DW)) & 64'hFFFF;
                d = (x > y) ? x - y : y - x;
                lacc[i] += m ? d : d*d;
                if (lacc[i] >= (64'd1 << ACC)) begin ovf = 1; lacc[i] -= (64'd1 << ACC); end
            end
        sum = 0;
        for (int i = 0; i < CH; i++) sum += lacc[i];
        e.ref_id = r; e.lat = -1; e.t = 0;
        if (bands == 0) begin
            e.val = 64'hFFFF_FFFF; e.dz = 1; e.of = 0; e.chk_of = 0;
        end else begin
            qt = sum / longint'(bands);
            e.val = (qt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : qt;
            e.of  = (qt > 64'hFFFF_FFFF) | ovf;
            e.dz = 0; e.chk_of = 1;
        end
        return e;
    endfunction

    task automatic beat(input bit s, input bit l, input bit m, input logic [31:0] a, input logic [31:0] b,
                        input int r, input int bd, output int t);
        int n = 0;
        @(negedge clk);
        bif.band_pack_valid = 1; bif.band_pack_start = s; bif.band_pack_last = l;
        bif.mode = m; bif.band_pack_a = a; bif.band_pack_b = b;
        bif.hsp_ref = LW'(r); bif.hsp_bands = BW'(bd);
        #1;
        while (!bif.band_pack_ready && n < 400) begin @(negedge clk); #1; n++; end
        if (n >= 400) begin
            chk("beat_timeout", 1, 0);
            bif.band_pack_valid = 0; t = 0;
        end else begin
            @(posedge clk); #1;
            bif.band_pack_valid = 0; t = cyc - 1; accepted++;
        end
    endtask

    task automatic send_vec(input bit m, input int r, input int bd, input int lat);
        int t = 0;
        exp_t e;
        e = model(m, r, bd);
        for (int j = 0; j < va.size(); j++)
            beat(j == 0, j == va.size()-1, (j == 0) ? m : 1'($urandom), va[j], vb[j], r, bd, t);
        e.lat = lat; e.t = t;
        q.push_back(e);
    endtask

    task automatic send_part();
        int t;
        for (int j = 0; j < va.size(); j++)
            beat(j == 0, 1'b0, 1'($urandom), va[j], vb[j], 0, 0, t);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 3000) begin @(negedge clk); n++; end
        chk("drain_timeout", longint'(n >= 3000), 0);
    endtask

    always @(negedge clk) begin
        if (bif.mse_valid && !seen) begin seen = 1; vcyc = cyc; end
        if (bif.mse_valid && bif.mse_ready) begin
            if (q.size() == 0) chk("spurious_result", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("value", bif.mse_value, e.val);
                chk("ref", bif.mse_ref, e.ref_id);
                chk("div_zero", bif.div_zero, e.dz);
                if (e.chk_of) chk("acc_of", bif.acc_of, e.of);
                if (e.lat >= 0) chk("latency", vcyc - e.t, e.lat);
            end
            last_val = bif.mse_value; last_ref = int'(bif.mse_ref);
            last_of = bif.acc_of; last_dz = bif.div_zero;
            results++; seen = 0;
        end else if (!bif.mse_valid) seen = 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r0, a0;
        bif.band_pack_valid = 0; bif.band_pack_start = 0; bif.band_pack_last = 0;
        bif.mode = 0; bif.band_pack_a = 0; bif.band_pack_b = 0;
        bif.hsp_ref = 0; bif.hsp_bands = 0; bif.mse_ready = 1;

        repeat (3) @(negedge clk);
        chk("rst_ready", bif.band_pack_ready, 0);
        chk("rst_valid", bif.mse_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_value", bif.mse_value, 0);
        chk("rst_flags", {bif.acc_of, bif.div_zero}, 0);
        rst = 0; #1;
        chk("post_rst_ready", bif.band_pack_ready, 1);

        va = '{32'h0005_0003, 32'h0005_0003, 32'h0005_0003, 32'h0005_0003};
        vb = '{32'h0001_0001, 32'h0001_0001, 32'h0001_0001, 32'h0001_0001};
        send_vec(0, 7, 8, 45); wait_drain();
        chk("mse4_value", last_val, 10); chk("mse4_ref", last_ref, 7);
        send_vec(1, 7, 8, 45); wait_drain();
        chk("mae4_value", last_val, 3);

        va = '{32'hFFFF_FFFF}; vb = '{32'h0};
        send_vec(0, 9, 1, 45); wait_drain();
        chk("sat_value", last_val, 64'hFFFF_FFFF); chk("sat_of", last_of, 1);

        va = '{32'h1234_5678, 32'h0}; vb = '{32'h0, 32'h9};
        send_vec(0, 4, 0, 4); wait_drain();
        chk("dz_value", last_val, 64'hFFFF_FFFF); chk("dz_flag", last_dz, 1);

        // partial vector abandoned by a fresh start
        va = '{32'hFFFF_FFFF, 32'hFFFF_FFFF}; vb = '{32'h0, 32'h0};
        send_part();
        va = '{32'h0002_0004}; vb = '{32'h0};
        send_vec(0, 5, 2, 45); wait_drain();
        chk("discard_value", last_val, 10);

        // backpressure with results held
        @(posedge clk); #1 bif.mse_ready = 0;
        a0 = accepted; r0 = results;
        fork
            for (int k = 1; k <= 3; k++) begin
                va = '{$urandom}; vb = '{$urandom};
                send_vec(0, k, 1 + k, -1);
            end
        join_none
        repeat (80) @(negedge clk);
        chk("bp_ready_low", bif.band_pack_ready, 0);
        chk("bp_accepted", accepted - a0, 2);
        chk("bp_valid_held", bif.mse_valid, 1);
        @(posedge clk); #1 bif.mse_ready = 1;
        wait fork;
        wait_drain();
        chk("bp_results", results - r0, 3);

        // clear during RUN with a partial vector accumulating
        va = '{32'h0100_0200}; vb = '{32'h0};
        send_vec(0, 11, 8, -1);
        va = '{32'h7777_7777}; vb = '{32'h0};
        send_part();
        repeat (3) @(negedge clk);
        clear = 1;
        @(posedge clk); #1 clear = 0;
        q.delete();
        @(negedge clk);
        chk("clr_busy", busy, 0);
        chk("clr_valid", bif.mse_valid, 0);
        chk("clr_ready", bif.band_pack_ready, 1);
        va = '{32'h0003_0001, 32'h0001_0003}; vb = '{32'h0001_0003, 32'h0003_0001};
        send_vec(0, 12, 2, 45); wait_drain();
        chk("clr_after_value", last_val, 8);

        rnd_on = 1;
        fork
            while (rnd_on) begin @(posedge clk); #1 bif.mse_ready = ($urandom_range(0, 3) != 0); end
        join_none
        for (int v = 0; v < 25; v++) begin
            int len, bd, sel;
            len = $urandom_range(1, 5);
            va.delete(); vb.delete();
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 1) == 1) begin va.push_back($urandom); vb.push_back($urandom); end
                else begin va.push_back($urandom & 32'h00FF_00FF); vb.push_back($urandom & 32'h00FF_00FF); end
            end
            sel = $urandom_range(0, 9);
            bd = (sel == 0) ? 0 : (sel == 1) ? 1 : $urandom_range(1, 511);
            if ($urandom_range(0, 7) == 0) send_part();
            else send_vec(1'($urandom), $urandom_range(0, 255), bd, -1);
        end
        rnd_on = 0;
        wait fork;
        bif.mse_ready = 1;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
